fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 100 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches sequential words from instruction memory
// into a DEPTH-entry circular buffer that feeds decode; redirects flush it.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_ready,
    input  logic [31:0]             imem_rdata,
    input  logic                    redirect,
    input  logic [XLEN-1:0]         redirect_pc,
    input  logic                    stall_d,
    output logic                    out_valid,
    output logic [31:0]             out_instr,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_pcplus4,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned      PTR_W = $clog2(DEPTH);
    localparam int unsigned      CNT_W = PTR_W + 1;
    localparam logic [31:0]      NOP   = 32'h0000_0013;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [XLEN-1:0]  pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             pop;
    logic             push;

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    // Low address bits of the redirect target are dropped on purpose.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    // A pop frees a slot in the same cycle, so a full queue can still fetch.
    always_comb begin
        out_valid = (cnt != '0);
        pop       = out_valid & ~stall_d & ~redirect;
        imem_req  = rst & ~redirect & ((cnt < FULL) | pop);
        push      = imem_req & imem_ready;
    end

    assign imem_addr = {2'b00, pc[XLEN-1:2]};
    assign count     = cnt;

    always_comb begin
        if (out_valid) begin
            out_instr = instr_mem[rd_ptr];
            out_pc    = pc_mem[rd_ptr];
        end else begin
            out_instr = NOP;
            out_pc    = '0;
        end
        out_pcplus4 = out_pc + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc     <= {RESET_PC[XLEN-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (redirect) begin
            pc     <= {redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                pc     <= pc + XLEN'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; validity is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule
